dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache for the MEM stage of the 5-stage pipeline.
- Sits between the EX/MEM pipeline buffer (load/store address and store data) and a multi-cycle off-chip data memory with a 256-bit line interface.
- Hits complete with no stall; misses stall the whole pipeline until the line is refilled.

---
 rtl/dcache_ctrl_pkg.sv | 18 +
 rtl/dcache_sram.sv | 57 +++++
 rtl/dcache_ctrl.sv | 114 +++++++++++
 tb/tb_dcache_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_ctrl_pkg.sv
// rtl/dcache_ctrl_pkg.sv - shared widths and FSM encoding for the data cache
package dcache_ctrl_pkg;
    localparam int ADDR_W   = 32;
    localparam int LINE_W   = 256;
    localparam int LINE_NUM = 32;
    localparam int IDX_W    = $clog2(LINE_NUM);
    localparam int OFF_W    = $clog2(LINE_W / 8);
    localparam int TAG_W    = ADDR_W - IDX_W - OFF_W;
    localparam int WORDS    = LINE_W / 32;
    localparam int WORD_W   = $clog2(WORDS);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2,
        ST_REFILL    = 2'd3
    } state_t;
endpackage

// File: rtl/dcache_sram.sv
// rtl/dcache_sram.sv - tag/valid/dirty/data arrays of the direct-mapped cache
// Ports: idx selects the line for both the asynchronous read and the write.
//   rd_*      : tag, valid, dirty and data of line idx (combinational)
//   line_we   : full-line fill (tag + data), sets valid, clears dirty
//   word_we   : per-word store enables, sets dirty
// Valid and dirty are cleared by rst_i; tag and data are not reset.
module dcache_sram
    import dcache_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  idx,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [LINE_W-1:0] rd_line,
    input  logic              line_we,
    input  logic [TAG_W-1:0]  line_tag,
    input  logic [LINE_W-1:0] line_data,
    input  logic [WORDS-1:0]  word_we,
    input  logic [31:0]       word_data
);
    logic [LINE_NUM-1:0] valid_q;
    logic [LINE_NUM-1:0] dirty_q;
    logic [TAG_W-1:0]    tag_mem  [LINE_NUM];
    logic [LINE_W-1:0]   data_mem [LINE_NUM];

    assign rd_tag   = tag_mem[idx];
    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_line  = data_mem[idx];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (|word_we) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (line_we) begin
            tag_mem[idx]  <= line_tag;
            data_mem[idx] <= line_data;
        end else begin
            for (int w = 0; w < WORDS; w++) begin
                if (word_we[w]) begin
                    data_mem[idx][w*32 +: 32] <= word_data;
                end
            end
        end
    end
endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate MEM-stage data cache
// Ports:
//   p1_*  : pipeline side; load/store request, store data, load data, stall
//   mem_* : line-wide memory side; enable/write/addr/data out, data/ack in
// Hits finish in the request cycle; misses stall through WRITEBACK (dirty
// victim), ALLOCATE and REFILL, after which the held request hits in IDLE.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p1_req_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_data_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);
    state_t              state;
    logic [TAG_W-1:0]    tag;
    logic [IDX_W-1:0]    idx;
    logic [WORD_W-1:0]   word;
    logic [1:0]          unused_byte_off;
    logic [TAG_W-1:0]    rd_tag;
    logic                rd_valid;
    logic                rd_dirty;
    logic [LINE_W-1:0]   rd_line;
    logic                hit;
    logic                line_we;
    logic [WORDS-1:0]    word_we;

    assign tag             = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign idx             = p1_addr_i[OFF_W +: IDX_W];
    assign word            = p1_addr_i[2 +: WORD_W];
    assign unused_byte_off = p1_addr_i[1:0];

    assign hit        = rd_valid && (rd_tag == tag);
    assign p1_stall_o = p1_req_i && (!hit || (state != ST_IDLE));
    // Gated by hit so the output is zero while the array is invalid after reset.
    assign p1_data_o  = hit ? rd_line[{word, 5'b0} +: 32] : 32'd0;

    // Stores only commit in IDLE; in REFILL the retried store waits one more
    // cycle so the fill and the merge never collide on the same line.
    assign word_we = (p1_req_i && p1_write_i && hit && state == ST_IDLE)
                   ? (WORDS'(1) << word) : '0;
    assign line_we = (state == ST_ALLOCATE) && mem_ack_i;

    dcache_sram u_sram (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .idx       (idx),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_line   (rd_line),
        .line_we   (line_we),
        .line_tag  (tag),
        .line_data (mem_data_i),
        .word_we   (word_we),
        .word_data (p1_data_i)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= ST_IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (p1_req_i && !hit) begin
                        mem_enable_o <= 1'b1;
                        if (rd_valid && rd_dirty) begin
                            state       <= ST_WRITEBACK;
                            mem_write_o <= 1'b1;
                            mem_addr_o  <= {rd_tag, idx, {OFF_W{1'b0}}};
                            mem_data_o  <= rd_line;
                        end else begin
                            state       <= ST_ALLOCATE;
                            mem_write_o <= 1'b0;
                            mem_addr_o  <= {tag, idx, {OFF_W{1'b0}}};
                        end
                    end
                end
                ST_WRITEBACK: begin
                    // Enable stays high straight into the fetch request.
                    if (mem_ack_i) begin
                        state       <= ST_ALLOCATE;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= {tag, idx, {OFF_W{1'b0}}};
                    end
                end
                ST_ALLOCATE: begin
                    if (mem_ack_i) begin
                        state        <= ST_REFILL;
                        mem_enable_o <= 1'b0;
                    end
                end
                ST_REFILL: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - self-checking bench for dcache_ctrl
module tb_dcache_ctrl;
    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         p1_req_i = 1'b0;
    logic         p1_write_i = 1'b0;
    logic [31:0]  p1_addr_i = '0;
    logic [31:0]  p1_data_i = '0;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;

    dcache_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .p1_req_i     (p1_req_i),
        .p1_write_i   (p1_write_i),
        .p1_addr_i    (p1_addr_i),
        .p1_data_i    (p1_data_i),
        .p1_data_o    (p1_data_o),
        .p1_stall_o   (p1_stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: cache contents per index plus a backing memory image.
    logic [255:0] m_line  [32];
    logic [21:0]  m_tag   [32];
    logic         m_valid [32];
    logic         m_dirty [32];
    logic [255:0] img [logic [31:0]];

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } mem_ev_t;
    mem_ev_t log_q[$];

    int   cur_lat = 3;
    logic auto_mem = 1'b1;
    logic man_ack = 1'b0;
    int   cnt = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        int          exp_stall;
        logic        exp_wb;
        logic [31:0] exp_wb_addr;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        if (img.exists(a)) return img[a];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = (a + 32'(w * 4)) ^ 32'h5A5A_0000;
        return l;
    endfunction

    // Memory responder: acks on the cur_lat-th cycle of each request.
    always @(negedge clk_i) begin
        mem_ack_i = 1'b0;
        if (auto_mem && rst_i && mem_enable_o) begin
            cnt++;
            if (cnt >= cur_lat) begin
                cnt = 0;
                mem_ack_i = 1'b1;
                mem_data_i = mem_write_o ? '0 : line_of(mem_addr_o);
                log_q.push_back('{mem_write_o, mem_addr_o, mem_data_o});
            end
        end else begin
            cnt = 0;
            mem_ack_i = man_ack;
        end
    end

    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output int stall_cyc, output logic [31:0] rdata,
                          output logic saw_wb, output logic [31:0] wb_addr);
        logic [4:0]   idx;
        logic [21:0]  tg;
        int           w;
        logic         exp_hit;
        logic         exp_wb;
        logic [31:0]  victim_addr;
        logic [255:0] victim_line;
        int           n_ev;
        idx = addr[9:5];
        tg = addr[31:10];
        w = int'(addr[4:2]);
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        exp_wb = !exp_hit && m_valid[idx] && m_dirty[idx];
        victim_addr = {m_tag[idx], idx, 5'b0};
        victim_line = m_line[idx];
        if (exp_wb) img[victim_addr] = victim_line;
        log_q.delete();
        @(negedge clk_i);
        p1_req_i = 1'b1;
        p1_write_i = wr;
        p1_addr_i = addr;
        p1_data_i = wdata;
        #1;
        stall_cyc = 0;
        while (p1_stall_o && stall_cyc < 100) begin
            @(negedge clk_i);
            #1;
            stall_cyc++;
        end
        chk("stall_timeout", 256'(stall_cyc < 100), 256'(1));
        rdata = p1_data_o;
        chk("hit", 256'(stall_cyc == 0), 256'(exp_hit));
        saw_wb = (log_q.size() > 0) && log_q[0].wr;
        wb_addr = saw_wb ? log_q[0].addr : 32'd0;
        if (!exp_hit) begin
            n_ev = exp_wb ? 2 : 1;
            chk("mem_req_count", 256'(log_q.size()), 256'(n_ev));
            if (log_q.size() == n_ev) begin
                if (exp_wb) begin
                    chk("wb_write", 256'(log_q[0].wr), 256'(1));
                    chk("wb_addr", 256'(log_q[0].addr), 256'(victim_addr));
                    chk("wb_data", log_q[0].data, victim_line);
                end
                chk("fetch_write", 256'(log_q[n_ev-1].wr), 256'(0));
                chk("fetch_addr", 256'(log_q[n_ev-1].addr), 256'({tg, idx, 5'b0}));
            end
            if (!exp_wb) chk("miss_latency", 256'(stall_cyc), 256'(cur_lat + 2));
            m_line[idx] = line_of({tg, idx, 5'b0});
            m_tag[idx] = tg;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
        end
        if (!wr) begin
            chk("load_data", 256'(rdata), 256'(m_line[idx][w*32 +: 32]));
        end else begin
            m_line[idx][w*32 +: 32] = wdata;
            m_dirty[idx] = 1'b1;
        end
        @(posedge clk_i);
        #1;
        p1_req_i = 1'b0;
    endtask

    initial begin
        int          sc;
        logic [31:0] rd;
        logic        swb;
        logic [31:0] wba;
        logic [31:0] snap_addr;
        logic [255:0] snap_data;

        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i] = '0;
            m_line[i] = '0;
        end

        vecs[0] = '{1'b0, 32'h0000_0040, 32'h0,         10, 12, 1'b0, 32'h0,  32'h5A5A_0040};
        vecs[1] = '{1'b1, 32'h0000_0044, 32'hDEAD_BEEF,  3,  0, 1'b0, 32'h0,  32'h0};
        vecs[2] = '{1'b0, 32'h0000_0044, 32'h0,          3,  0, 1'b0, 32'h0,  32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 32'h0000_0444, 32'h0,          3, -1, 1'b1, 32'h40, 32'h5A5A_0444};
        vecs[4] = '{1'b1, 32'h0000_0080, 32'h1234_5678, 10, 12, 1'b0, 32'h0,  32'h0};
        vecs[5] = '{1'b0, 32'h0000_0080, 32'h0,          3,  0, 1'b0, 32'h0,  32'h1234_5678};
        vecs[6] = '{1'b0, 32'h0000_0044, 32'h0,          3,  5, 1'b0, 32'h0,  32'hDEAD_BEEF};
        vecs[7] = '{1'b0, 32'h0000_1080, 32'h0,          3, -1, 1'b1, 32'h80, 32'h5A5A_1080};
        vecs[8] = '{1'b0, 32'h0000_0084, 32'h0,          3,  5, 1'b0, 32'h0,  32'h5A5A_0084};

        // Reset values.
        #12;
        chk("rst_stall", 256'(p1_stall_o), 256'(0));
        chk("rst_mem_enable", 256'(mem_enable_o), 256'(0));
        chk("rst_mem_write", 256'(mem_write_o), 256'(0));
        chk("rst_mem_addr", 256'(mem_addr_o), 256'(0));
        chk("rst_mem_data", mem_data_o, 256'(0));
        p1_req_i = 1'b1;
        p1_addr_i = 32'h40;
        #1;
        chk("rst_stall_req", 256'(p1_stall_o), 256'(1));
        chk("rst_p1_data", 256'(p1_data_o), 256'(0));
        p1_req_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            cur_lat = vecs[i].lat;
            access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, sc, rd, swb, wba);
            if (vecs[i].exp_stall >= 0) chk($sformatf("vec%0d_stall", i), 256'(sc), 256'(vecs[i].exp_stall));
            chk($sformatf("vec%0d_wb", i), 256'(swb), 256'(vecs[i].exp_wb));
            if (vecs[i].exp_wb) chk($sformatf("vec%0d_wb_addr", i), 256'(wba), 256'(vecs[i].exp_wb_addr));
            if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), 256'(rd), 256'(vecs[i].exp_rdata));
        end

        // Spurious ack in IDLE with no request: nothing may change.
        auto_mem = 1'b0;
        snap_addr = mem_addr_o;
        snap_data = mem_data_o;
        @(posedge clk_i);
        #1;
        man_ack = 1'b1;
        mem_data_i = {8{32'hBAD0_BAD0}};
        @(posedge clk_i);
        #1;
        man_ack = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("spur_enable", 256'(mem_enable_o), 256'(0));
        chk("spur_addr", 256'(mem_addr_o), 256'(snap_addr));
        chk("spur_data", mem_data_o, snap_data);
        auto_mem = 1'b1;
        access(1'b0, 32'h0000_0084, 32'h0, sc, rd, swb, wba);
        chk("spur_rehit_stall", 256'(sc), 256'(0));

        // Reset during ALLOCATE.
        auto_mem = 1'b0;
        @(negedge clk_i);
        p1_req_i = 1'b1;
        p1_write_i = 1'b0;
        p1_addr_i = 32'h0000_0100;
        #1;
        chk("alloc_stall", 256'(p1_stall_o), 256'(1));
        repeat (3) @(negedge clk_i);
        #1;
        chk("alloc_enable", 256'(mem_enable_o), 256'(1));
        chk("alloc_write", 256'(mem_write_o), 256'(0));
        chk("alloc_addr", 256'(mem_addr_o), 256'(32'h100));
        #2;
        rst_i = 1'b0;
        #1;
        chk("midrst_enable", 256'(mem_enable_o), 256'(0));
        chk("midrst_addr", 256'(mem_addr_o), 256'(0));
        @(negedge clk_i);
        p1_req_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        @(posedge clk_i);
        #1;
        man_ack = 1'b1;
        @(posedge clk_i);
        #1;
        man_ack = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("late_ack_enable", 256'(mem_enable_o), 256'(0));
        chk("late_ack_stall", 256'(p1_stall_o), 256'(0));
        auto_mem = 1'b1;
        cur_lat = 4;
        access(1'b0, 32'h0000_0040, 32'h0, sc, rd, swb, wba);
        chk("post_reset_miss", 256'(sc), 256'(6));

        // Randomized traffic over a few indices and tags to force conflicts.
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 5)
              | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            cur_lat = $urandom_range(1, 5);
            access(1'($urandom_range(0, 1)), a, $urandom, sc, rd, swb, wba);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
